// File: rtl/gpio_cond_pkg.sv
// Shared constants and width helper for the GPIO input conditioning path.
package gpio_cond_pkg;

    localparam int GPIO_COND_WIDTH      = 16;
    localparam int GPIO_COND_TICK_DIV   = 50000;
    localparam int GPIO_COND_STABLE_CNT = 4;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gpio_in_conditioner_debounce_bit.sv
// One GPIO bit: 2-flop synchronizer, tick-sampled debouncer, edge pulses and sticky rise flag.
module debounce_bit
    import gpio_cond_pkg::*;
#(
    parameter int STABLE_CNT = GPIO_COND_STABLE_CNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic tick,
    input  logic clear,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic sticky
);

    localparam int CW = cnt_width(STABLE_CNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          rise_nxt;
    logic          fall_nxt;

    always_comb begin
        accept   = tick && (s2 != dout) && (cnt == CNT_MAX);
        rise_nxt = accept && s2;
        fall_nxt = accept && !s2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            dout   <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            sticky <= 1'b0;
        end else begin
            s1     <= din;
            s2     <= s1;
            rise   <= rise_nxt;
            fall   <= fall_nxt;
            // A rise in the same cycle as a clear must still be recorded.
            sticky <= rise_nxt | (sticky & ~clear);
            if (tick) begin
                if (s2 == dout) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    dout <= s2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/gpio_in_conditioner.sv
// Conditions the raw GPIO input half: shared sample prescaler plus one debouncer per bit.
module gpio_in_conditioner
    import gpio_cond_pkg::*;
#(
    parameter int WIDTH      = GPIO_COND_WIDTH,
    parameter int TICK_DIV   = GPIO_COND_TICK_DIV,
    parameter int STABLE_CNT = GPIO_COND_STABLE_CNT
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] Din,
    input  logic [WIDTH-1:0] Clear,
    output logic [WIDTH-1:0] Dout,
    output logic [WIDTH-1:0] Rise,
    output logic [WIDTH-1:0] Fall,
    output logic [WIDTH-1:0] Sticky,
    output logic             Tick
);

    localparam int PW = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre;

    // Tick is registered on the wrap, so with TICK_DIV=1 it stays high every cycle.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pre  <= '0;
            Tick <= 1'b0;
        end else if (pre == PRE_MAX) begin
            pre  <= '0;
            Tick <= 1'b1;
        end else begin
            pre  <= pre + PW'(1);
            Tick <= 1'b0;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_CNT(STABLE_CNT)
        ) u_bit (
            .clk   (Clock),
            .rst_n (Resetn),
            .din   (Din[i]),
            .tick  (Tick),
            .clear (Clear[i]),
            .dout  (Dout[i]),
            .rise  (Rise[i]),
            .fall  (Fall[i]),
            .sticky(Sticky[i])
        );
    end

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Bench for gpio_in_conditioner: two configurations run side by side against a tick/run-length model.
module tb_gpio_in_conditioner;

    logic        Clock;
    logic        Resetn;
    logic [15:0] Din;
    logic [15:0] Clear;

    logic [15:0] dout_a, rise_a, fall_a, sticky_a;
    logic        tick_a;
    logic [15:0] dout_b, rise_b, fall_b, sticky_b;
    logic        tick_b;

    int n_chk;
    int n_fail;

    gpio_in_conditioner #(.WIDTH(16), .TICK_DIV(4), .STABLE_CNT(3)) dut_a (
        .Clock(Clock), .Resetn(Resetn), .Din(Din), .Clear(Clear),
        .Dout(dout_a), .Rise(rise_a), .Fall(fall_a), .Sticky(sticky_a), .Tick(tick_a)
    );

    gpio_in_conditioner #(.WIDTH(16), .TICK_DIV(1), .STABLE_CNT(1)) dut_b (
        .Clock(Clock), .Resetn(Resetn), .Din(Din), .Clear(Clear),
        .Dout(dout_b), .Rise(rise_b), .Fall(fall_b), .Sticky(sticky_b), .Tick(tick_b)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, index 0 = (TICK_DIV 4, STABLE 3), index 1 = (1, 1).
    // Pin level seen by the debouncer is Din two edges old; a new level is taken
    // once it has disagreed with the accepted level on STABLE consecutive ticks.
    logic [15:0] m_q1[2], m_q2[2], m_dout[2], m_rise[2], m_fall[2], m_sticky[2];
    int          m_run[2][16];
    int          m_k[2];
    logic        m_tick[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_q1[i] = '0; m_q2[i] = '0; m_dout[i] = '0;
            m_rise[i] = '0; m_fall[i] = '0; m_sticky[i] = '0;
            m_k[i] = 0; m_tick[i] = 1'b0;
            for (int b = 0; b < 16; b++) m_run[i][b] = 0;
        end
    endtask

    task automatic model_step(input int i, input int td, input int sc);
        logic [15:0] seen;
        seen      = m_q2[i];
        m_q2[i]   = m_q1[i];
        m_q1[i]   = Din;
        m_rise[i] = '0;
        m_fall[i] = '0;
        if (m_tick[i]) begin
            for (int b = 0; b < 16; b++) begin
                if (seen[b] != m_dout[i][b]) begin
                    m_run[i][b] = m_run[i][b] + 1;
                    if (m_run[i][b] == sc) begin
                        m_dout[i][b] = seen[b];
                        if (seen[b]) m_rise[i][b] = 1'b1;
                        else         m_fall[i][b] = 1'b1;
                        m_run[i][b] = 0;
                    end
                end else begin
                    m_run[i][b] = 0;
                end
            end
        end
        m_sticky[i] = (m_sticky[i] & ~Clear) | m_rise[i];
        m_k[i]      = m_k[i] + 1;
        m_tick[i]   = ((m_k[i] % td) == 0);
    endtask

    task automatic compare_all();
        chk("a_dout",   dout_a,   m_dout[0]);
        chk("a_rise",   rise_a,   m_rise[0]);
        chk("a_fall",   fall_a,   m_fall[0]);
        chk("a_sticky", sticky_a, m_sticky[0]);
        chk("a_tick",   tick_a,   m_tick[0]);
        chk("a_rise_fall_excl", rise_a & fall_a, 0);
        chk("b_dout",   dout_b,   m_dout[1]);
        chk("b_rise",   rise_b,   m_rise[1]);
        chk("b_fall",   fall_b,   m_fall[1]);
        chk("b_sticky", sticky_b, m_sticky[1]);
        chk("b_tick",   tick_b,   m_tick[1]);
    endtask

    // One clock: model advances on the posedge, outputs compared on the negedge.
    task automatic step();
        @(posedge Clock);
        if (!Resetn) begin
            model_reset();
        end else begin
            model_step(0, 4, 3);
            model_step(1, 1, 1);
        end
        @(negedge Clock);
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    task automatic pulse_reset();
        Resetn = 1'b0;
        model_reset();
        #1;
        chk("rst_async_dout", dout_a, 0);
        chk("rst_async_tick", tick_a, 0);
        step();
        Resetn = 1'b1;
    endtask

    initial begin
        int          nfall;
        logic [15:0] fall_seen;
        logic [15:0] rise_seen;

        n_chk  = 0;
        n_fail = 0;
        Resetn = 1'b0;
        Din    = 16'hFFFF;
        Clear  = 16'h0000;
        model_reset();

        // Reset with all pins high, then watch the first debounce complete.
        steps(3);
        chk("t1_rst_dout",   dout_a,   0);
        chk("t1_rst_sticky", sticky_a, 0);
        chk("t1_rst_rise",   rise_a,   0);
        Resetn = 1'b1;
        steps(12);
        chk("t1_dout_early", dout_a, 16'h0000);
        step();
        chk("t1_dout",   dout_a,   16'hFFFF);
        chk("t1_rise",   rise_a,   16'hFFFF);
        chk("t1_sticky", sticky_a, 16'hFFFF);
        step();
        chk("t1_rise_once", rise_a, 16'h0000);

        // Glitch shorter than the stable window on bit 0.
        Din = 16'h0000;
        steps(20);
        Clear = 16'hFFFF;
        step();
        Clear = 16'h0000;
        rise_seen = '0;
        Din = 16'h0001;
        for (int j = 0; j < 8; j++) begin step(); rise_seen |= rise_a; end
        Din = 16'h0000;
        for (int j = 0; j < 20; j++) begin step(); rise_seen |= rise_a; end
        chk("t2_dout0",   dout_a[0],   1'b0);
        chk("t2_rise0",   rise_seen[0], 1'b0);
        chk("t2_sticky0", sticky_a[0], 1'b0);

        // Clean single-bit fall.
        Din = 16'h00A5;
        steps(20);
        chk("t3_dout_pre", dout_a, 16'h00A5);
        Din = 16'h0085;
        nfall = 0; fall_seen = '0; rise_seen = '0;
        for (int j = 0; j < 20; j++) begin
            step();
            if (fall_a != 0) nfall++;
            fall_seen |= fall_a;
            rise_seen |= rise_a;
        end
        chk("t3_dout",      dout_a,    16'h0085);
        chk("t3_fall_cnt",  nfall,     1);
        chk("t3_fall_bits", fall_seen, 16'h0020);
        chk("t3_no_rise",   rise_seen, 16'h0000);

        // Clear held across the cycle in which Rise[3] fires: set must win.
        Clear = 16'hFFFF;
        Din   = 16'h008D;
        for (int j = 0; j < 40 && !m_rise[0][3]; j++) step();
        chk("t4_rise3",  rise_a,   16'h0008);
        chk("t4_sticky", sticky_a, 16'h0008);
        Clear = 16'h0000;
        step();
        chk("t4_sticky_hold", sticky_a, 16'h0008);

        // Reset in the middle of a debounce throws the partial count away.
        Din = 16'h0000;
        steps(20);
        Din = 16'h0080;
        steps(10);
        chk("t5_dout_pre", dout_a[7], 1'b0);
        pulse_reset();
        steps(12);
        chk("t5_dout_early", dout_a[7], 1'b0);
        step();
        chk("t5_dout", dout_a[7], 1'b1);

        // Fastest configuration: three cycles from pin to Dout.
        Din = 16'h0000;
        pulse_reset();
        steps(5);
        Din = 16'h1234;
        steps(2);
        chk("t6_dout_early", dout_b, 16'h0000);
        step();
        chk("t6_dout", dout_b, 16'h1234);
        chk("t6_rise", rise_b, 16'h1234);
        Din = 16'h0000;
        steps(3);
        chk("t6_fall",     fall_b, 16'h1234);
        chk("t6_dout_low", dout_b, 16'h0000);

        // Random pins, clears and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) Din = Din ^ 16'($urandom & $urandom & $urandom);
            Clear = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'h0000;
            if ($urandom_range(0, 499) == 0) pulse_reset();
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
